// File: rtl/mips_pkg.sv
// Shared EX-stage definitions: mul/div opcode encoding, FSM state encoding
// and small opcode decode helpers.
package mips_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic op_is_signed(input op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/hilo_reg.sv
// HI/LO architectural register pair sharing a single write enable.
module hilo_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             we,
  input  logic [WIDTH-1:0] hi_next,
  input  logic [WIDTH-1:0] lo_next,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  logic [1:0][WIDTH-1:0] d_pack;
  logic [1:0][WIDTH-1:0] q_pack;

  assign d_pack = {hi_next, lo_next};

  // Word 1 is HI, word 0 is LO.
  for (genvar gi = 0; gi < 2; gi++) begin : g_word
    logic [WIDTH-1:0] word_reg;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        word_reg <= '0;
      end else if (we) begin
        word_reg <= d_pack[gi];
      end
    end

    assign q_pack[gi] = word_reg;
  end

  assign hi = q_pack[1];
  assign lo = q_pack[0];

endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative EX-stage multiply (shift-add) / divide (restoring) unit writing HI/LO.
// Works on operand magnitudes and applies the sign fixup in a dedicated cycle.
module ex_muldiv_unit
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] rs_data_i,
  input  logic [WIDTH-1:0] rt_data_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  state_e             state_reg, state_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;
  logic [2*WIDTH-1:0] acc_reg, acc_next;
  logic [WIDTH-1:0]   opb_reg, opb_next;
  logic [WIDTH-1:0]   rs_raw_reg, rs_raw_next;
  logic               div_reg, div_next;
  logic               neg_q_reg, neg_q_next;
  logic               neg_r_reg, neg_r_next;
  logic               div0_reg, div0_next;

  op_e              op;
  logic             rs_neg, rt_neg;
  logic [WIDTH-1:0] rs_mag, rt_mag;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH:0]   div_diff;
  logic [2*WIDTH-1:0] mul_step, div_step, prod_fix;
  logic [WIDTH-1:0] quot, rem;
  logic [WIDTH-1:0] hi_fix, lo_fix;
  logic             hilo_we;

  assign op     = op_e'(op_i);
  assign rs_neg = op_is_signed(op) & rs_data_i[WIDTH-1];
  assign rt_neg = op_is_signed(op) & rt_data_i[WIDTH-1];
  assign rs_mag = rs_neg ? -rs_data_i : rs_data_i;
  assign rt_mag = rt_neg ? -rt_data_i : rt_data_i;

  // acc = {partial product, remaining multiplier bits}; add then shift right.
  assign mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + {1'b0, opb_reg};
  assign mul_step = acc_reg[0] ? {mul_sum, acc_reg[WIDTH-1:1]}
                               : {1'b0, acc_reg[2*WIDTH-1:1]};

  // acc = {remainder, dividend bits / quotient bits}; shift left, trial subtract.
  assign rem_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
  assign div_diff = rem_sh - {1'b0, opb_reg};
  assign div_step = div_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc_reg[WIDTH-2:0], 1'b1};

  assign prod_fix = neg_q_reg ? -acc_reg : acc_reg;
  assign quot     = acc_reg[WIDTH-1:0];
  assign rem      = acc_reg[2*WIDTH-1:WIDTH];

  always_comb begin
    hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix = prod_fix[WIDTH-1:0];
    if (div_reg) begin
      if (div0_reg) begin
        hi_fix = rs_raw_reg;
        lo_fix = '1;
      end else begin
        hi_fix = neg_r_reg ? -rem : rem;
        lo_fix = neg_q_reg ? -quot : quot;
      end
    end
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    acc_next    = acc_reg;
    opb_next    = opb_reg;
    rs_raw_next = rs_raw_reg;
    div_next    = div_reg;
    neg_q_next  = neg_q_reg;
    neg_r_next  = neg_r_reg;
    div0_next   = div0_reg;
    hilo_we     = 1'b0;
    stall_o     = 1'b0;
    if (flush) begin
      state_next = IDLE;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            stall_o     = 1'b1;
            state_next  = RUN;
            cnt_next    = '0;
            acc_next    = {{WIDTH{1'b0}}, rs_mag};
            opb_next    = rt_mag;
            rs_raw_next = rs_data_i;
            div_next    = op_is_div(op);
            neg_q_next  = rs_neg ^ rt_neg;
            neg_r_next  = rs_neg;
            div0_next   = op_is_div(op) && (rt_data_i == '0);
          end
        end
        RUN: begin
          stall_o  = 1'b1;
          acc_next = div_reg ? div_step : mul_step;
          cnt_next = cnt_reg + CNT_W'(1);
          if (cnt_reg == CNT_W'(WIDTH - 1)) begin
            state_next = FIX;
            cnt_next   = '0;
          end
        end
        FIX: begin
          stall_o    = 1'b1;
          hilo_we    = 1'b1;
          state_next = DONE;
        end
        DONE: begin
          // The issuing instruction leaves EX now; start_i still refers to it.
          state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase
    end
    if (!rst) begin
      stall_o = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg  <= IDLE;
      cnt_reg    <= '0;
      acc_reg    <= '0;
      opb_reg    <= '0;
      rs_raw_reg <= '0;
      div_reg    <= 1'b0;
      neg_q_reg  <= 1'b0;
      neg_r_reg  <= 1'b0;
      div0_reg   <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      acc_reg    <= acc_next;
      opb_reg    <= opb_next;
      rs_raw_reg <= rs_raw_next;
      div_reg    <= div_next;
      neg_q_reg  <= neg_q_next;
      neg_r_reg  <= neg_r_next;
      div0_reg   <= div0_next;
    end
  end

  assign busy_o = (state_reg != IDLE);

  hilo_reg #(
    .WIDTH(WIDTH)
  ) u_hilo (
    .clk     (clk),
    .rst     (rst),
    .we      (hilo_we),
    .hi_next (hi_fix),
    .lo_next (lo_fix),
    .hi      (hi_o),
    .lo      (lo_o)
  );

endmodule

// File: tb/tb_ex_muldiv_unit.sv
// Bench for ex_muldiv_unit: fixed vectors, flush/reset sequences and random
// operations checked against a 64-bit arithmetic reference model.
module tb_ex_muldiv_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         flush = 1'b0;
  logic         start_i = 1'b0;
  logic [1:0]   op_i = 2'b00;
  logic [W-1:0] rs_data_i = '0;
  logic [W-1:0] rt_data_i = '0;
  logic         stall_o;
  logic         busy_o;
  logic [W-1:0] hi_o;
  logic [W-1:0] lo_o;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ex_muldiv_unit #(
    .WIDTH(W),
    .CNT_W(6)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .start_i   (start_i),
    .op_i      (op_i),
    .rs_data_i (rs_data_i),
    .rt_data_i (rt_data_i),
    .stall_o   (stall_o),
    .busy_o    (busy_o),
    .hi_o      (hi_o),
    .lo_o      (lo_o)
  );

  typedef struct {
    logic [1:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic with the architectural special cases.
  task automatic model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo);
    logic signed [63:0] sa, sb, sp, sq, sr;
    logic [63:0] ua, ub, up;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    hi = '0;
    lo = '0;
    case (op)
      2'b00: begin sp = sa * sb; hi = sp[63:32]; lo = sp[31:0]; end
      2'b01: begin up = ua * ub; hi = up[63:32]; lo = up[31:0]; end
      default: begin
        if (b == 32'd0) begin
          hi = a;
          lo = 32'hFFFF_FFFF;
        end else if (op == 2'b10) begin
          sq = sa / sb;
          sr = sa % sb;
          hi = sr[31:0];
          lo = sq[31:0];
        end else begin
          up = ua / ub;
          hi = a % b;
          lo = up[31:0];
        end
      end
    endcase
  endtask

  // Issues one operation, scrambles operands during RUN, holds start_i through DONE.
  task automatic do_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] hi, output logic [31:0] lo, output int stalls);
    @(posedge clk); #1;
    start_i   = 1'b1;
    op_i      = op;
    rs_data_i = a;
    rt_data_i = b;
    stalls    = 0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      if (!stall_o) break;
      stalls++;
      if (c == 0) begin
        @(posedge clk); #1;
        rs_data_i = $urandom;
        rt_data_i = $urandom;
      end
    end
    check("done_busy", 32'(busy_o), 32'd1);
    hi = hi_o;
    lo = lo_o;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(negedge clk);
    check("idle_after_done", {30'b0, busy_o, stall_o}, 32'd0);
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0:       return 32'h0000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] hi, lo, ehi, elo, prev_hi, prev_lo, a, b;
    logic [1:0]  op;
    int          stalls;

    vecs[0] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1] = '{2'b00, 32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3] = '{2'b01, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000};
    vecs[4] = '{2'b11, 32'h0000_0007, 32'h0000_0002, 32'h0000_0001, 32'h0000_0003};
    vecs[5] = '{2'b11, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF};
    vecs[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[7] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vecs[9] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};

    // Reset with start_i asserted: outputs must stay quiet.
    rst     = 1'b0;
    start_i = 1'b1;
    op_i    = 2'b01;
    #12;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_hi", hi_o, 32'd0);
    check("rst_lo", lo_o, 32'd0);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 10; i++) begin
      do_op(vecs[i].op, vecs[i].rs, vecs[i].rt, hi, lo, stalls);
      check($sformatf("vec%0d_stall", i), 32'(stalls), 32'd34);
      check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
      check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
      $display("vec %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h stalls=%0d",
               i, vecs[i].op, vecs[i].rs, vecs[i].rt, hi, lo, stalls);
    end
    prev_hi = vecs[9].hi;
    prev_lo = vecs[9].lo;

    // Flush during RUN iteration 10: no write, back to IDLE.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b00; rs_data_i = 32'd3; rt_data_i = 32'd5;
    @(negedge clk);
    check("flush_accept_stall", 32'(stall_o), 32'd1);
    repeat (11) @(posedge clk);
    #1;
    flush   = 1'b1;
    start_i = 1'b0;
    @(negedge clk);
    check("flush_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    @(negedge clk);
    check("flush_idle", {30'b0, busy_o, stall_o}, 32'd0);
    repeat (40) @(negedge clk);
    check("flush_hi_kept", hi_o, prev_hi);
    check("flush_lo_kept", lo_o, prev_lo);
    $display("flush run: hi=%h lo=%h", hi_o, lo_o);

    // Flush beats start_i in IDLE.
    @(posedge clk); #1;
    start_i = 1'b1; flush = 1'b1;
    @(negedge clk);
    check("flush_idle_stall", 32'(stall_o), 32'd0);
    @(posedge clk); #1;
    start_i = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_idle_busy", 32'(busy_o), 32'd0);
    $display("flush idle: busy=%0d", busy_o);

    // Asynchronous reset mid-RUN clears everything immediately.
    @(posedge clk); #1;
    start_i = 1'b1; op_i = 2'b01; rs_data_i = 32'h1234_5678; rt_data_i = 32'h9ABC_DEF0;
    repeat (6) @(posedge clk);
    #1;
    check("pre_rst_busy", 32'(busy_o), 32'd1);
    rst = 1'b0;
    #1;
    check("midrst_busy", 32'(busy_o), 32'd0);
    check("midrst_stall", 32'(stall_o), 32'd0);
    check("midrst_hi", hi_o, 32'd0);
    check("midrst_lo", lo_o, 32'd0);
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("post_rst_busy", 32'(busy_o), 32'd0);
    $display("mid-run reset: hi=%h lo=%h", hi_o, lo_o);

    for (int i = 0; i < 40; i++) begin
      op = 2'($urandom_range(0, 3));
      a  = pick_val();
      b  = pick_val();
      model(op, a, b, ehi, elo);
      do_op(op, a, b, hi, lo, stalls);
      check($sformatf("rnd%0d_stall", i), 32'(stalls), 32'd34);
      check($sformatf("rnd%0d_hi", i), hi, ehi);
      check($sformatf("rnd%0d_lo", i), lo, elo);
      $display("rnd %0d op=%0d rs=%h rt=%h -> hi=%h lo=%h (model %h %h)",
               i, op, a, b, hi, lo, ehi, elo);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
